cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run controller for the single-cycle MIPS CPU. It gates the CPU's global advance enable so a host or bench can run, single-step, halt, or run for a fixed instruction budget, with an optional PC breakpoint. It sits between the top-level clock/reset and the CPU's PC, register-file and data-memory write enables. It replaces ad-hoc "stop after N cycles" logic with a deterministic hardware halt.

## Interface
- RUN_LIMIT_W, 32, width of the instruction budget and retired counter
- PC_W, 32, width of the PC and breakpoint address
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous assert, active-low (low = reset)
- cmd_valid  in  1  host command strobe, sampled on the rising edge
- cmd_op  in  2  00 NOP, 01 RUN, 10 STEP, 11 HALT
- run_limit  in  RUN_LIMIT_W  budget captured on RUN accept; 0 = unlimited
- pc  in  PC_W  CPU current PC (instruction about to execute)
- bp_valid  in  1  breakpoint armed (only with the breakpoint macro)
- bp_addr  in  PC_W  breakpoint PC (only with the breakpoint macro)
- cpu_en  out  1  CPU advance enable; when 0, no PC, register or memory update
- state  out  2  00 IDLE, 01 RUN, 10 STEP, 11 HALTED
- retired  out  RUN_LIMIT_W  instructions retired since the last RUN/STEP accept
- halt_cause  out  2  00 STEP done, 01 host HALT, 10 limit reached, 11 breakpoint
- done  out  1  one-cycle pulse on entry to HALTED

## Operation
- Reset values: state IDLE, cpu_en 0, retired 0, halt_cause 00, done 0. The captured limit register resets to 0.
- Transition from IDLE or HALTED:
  - RUN goes to RUN. It clears retired and captures run_limit.
  - STEP goes to STEP. It clears retired.
  - HALT and NOP are ignored.
- Transitions out of RUN:
  - HALT goes to HALTED with cause 01.
  - RUN and STEP are ignored.
- STEP lasts exactly one cycle, then goes to HALTED with cause 00. Commands arriving during STEP are ignored.
- cpu_en is combinational: 1 in STEP, 1 in RUN unless a breakpoint hits this cycle, otherwise 0.
- retired increments on every cycle with cpu_en=1 and saturates at all-ones.
- Limit: in RUN with a nonzero captured limit, the cycle in which retired+1 equals the limit executes. The FSM then goes to HALTED with cause 10, so exactly `limit` instructions retire.
- Priority on the same edge, highest first: breakpoint, then limit, then host HALT. The cause reflects the winner.
- HALTED holds cpu_en=0 until a new RUN or STEP is accepted.

## Timing
- A command accepted on edge T takes effect on cpu_en from T onward. cpu_en is 1 in the cycle between T and T+1.
- HALT accepted on edge T: the instruction during cycle T-1→T has already retired. cpu_en is 0 after T.
- done rises for the single cycle following the edge that enters HALTED.
- Breakpoint hit: cpu_en drops in the same cycle, so the instruction at bp_addr does not execute. HALTED follows on the next edge.
- Reset asserted mid-RUN: cpu_en falls immediately (async), and the state returns to IDLE with no done pulse.

## Configuration
- CPU_RUN_CTRL_BREAKPOINT_EN defined: the bp_valid and bp_addr ports exist.
  - A hit is bp_valid && pc==bp_addr in RUN.
  - A hit is suppressed in the first RUN cycle after accept, so resuming from a breakpoint executes that instruction.
- Macro undefined: the ports are absent, no hit ever occurs, and cause 11 is never produced.

## Structure
- Shared package cpu_dbg_pkg holds:
  - the state encoding (IDLE/RUN/STEP/HALTED)
  - the cmd_op codes
  - the halt_cause codes
  - RUN_LIMIT_W default
- One sub-module, cpu_run_counter: a saturating retired counter with synchronous clear, plus the limit-compare output.

## Test plan
- Reset released, no command → state IDLE, cpu_en 0, retired 0 indefinitely.
- RUN with run_limit=30, CPU starting at PC 0x3000 → exactly 30 cycles with cpu_en=1. Then state HALTED, halt_cause 10, retired 30, one done pulse.
- Three STEP commands from IDLE → cpu_en high for one cycle each, retired 1 after each, halt_cause 00.
- RUN with limit 0, HALT at cycle 12 → retired 12, halt_cause 01. A HALT issued when already HALTED changes nothing.
- Macro defined: bp_addr=0x3010, bp_valid=1, RUN from 0x3000 → halt with pc=0x3010, retired 4, cause 11. A new RUN then executes 0x3010.
- Reset pulled low while in RUN at retired 7 → cpu_en 0 with no clock edge. After release: IDLE, retired 0.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared encodings and default widths for the CPU run controller.
package cpu_dbg_pkg;
    localparam int RUN_LIMIT_W_DEF = 32;
    localparam int PC_W_DEF = 32;
    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_STEP = 2'b10, ST_HALTED = 2'b11} state_e;
    typedef enum logic [1:0] {CMD_NOP = 2'b00, CMD_RUN = 2'b01, CMD_STEP = 2'b10, CMD_HALT = 2'b11} cmd_e;
    typedef enum logic [1:0] {CAUSE_STEP = 2'b00, CAUSE_HOST = 2'b01, CAUSE_LIMIT = 2'b10, CAUSE_BP = 2'b11} cause_e;
endpackage

// File: rtl/cpu_run_counter.sv
// cpu_run_counter: saturating retired-instruction counter with sync clear and limit compare.
module cpu_run_counter
    import cpu_dbg_pkg::*;
#(
    parameter int W = RUN_LIMIT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         last
);
    logic [W-1:0] count_q, count_d;
    always_comb count_d = clr ? '0 : (inc && !(&count_q)) ? count_q + W'(1) : count_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    assign count = count_q;
    // the retiring instruction that brings the count up to a nonzero limit is the final one
    assign last = (limit != '0) && (count_q + W'(1) == limit);
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/halt gating of the CPU advance enable with an instruction budget.
// Defining CPU_RUN_CTRL_BREAKPOINT_EN adds the bp_valid/bp_addr PC breakpoint.
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int RUN_LIMIT_W = RUN_LIMIT_W_DEF,
    parameter int PC_W        = PC_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    input  logic [1:0]             cmd_op,
    input  logic [RUN_LIMIT_W-1:0] run_limit,
    input  logic [PC_W-1:0]        pc,
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    input  logic                   bp_valid,
    input  logic [PC_W-1:0]        bp_addr,
`endif
    output logic                   cpu_en,
    output logic [1:0]             state,
    output logic [RUN_LIMIT_W-1:0] retired,
    output logic [1:0]             halt_cause,
    output logic                   done
);
    state_e                 state_q, state_d;
    cause_e                 cause_q, cause_d;
    logic [RUN_LIMIT_W-1:0] limit_q, limit_d;
    logic                   done_q, done_d, clr, last, bp_hit;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic first_q, first_d;
    // suppressed on the first RUN cycle so resuming executes the breakpoint instruction
    assign bp_hit  = state_q == ST_RUN && !first_q && bp_valid && pc == bp_addr;
    assign first_d = state_d == ST_RUN && state_q != ST_RUN;
    always_ff @(posedge clk or negedge rst)
        if (!rst) first_q <= 1'b0;
        else      first_q <= first_d;
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign bp_hit    = 1'b0;
`endif
    assign cpu_en = state_q == ST_STEP || (state_q == ST_RUN && !bp_hit);
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        limit_d = limit_q;
        clr     = 1'b0;
        case (state_q)
            ST_RUN:
                if (bp_hit || last || (cmd_valid && cmd_op == CMD_HALT)) begin
                    state_d = ST_HALTED;
                    cause_d = bp_hit ? CAUSE_BP : last ? CAUSE_LIMIT : CAUSE_HOST;
                end
            ST_STEP: begin
                state_d = ST_HALTED;
                cause_d = CAUSE_STEP;
            end
            default:
                if (cmd_valid && (cmd_op == CMD_RUN || cmd_op == CMD_STEP)) begin
                    state_d = cmd_op == CMD_RUN ? ST_RUN : ST_STEP;
                    limit_d = cmd_op == CMD_RUN ? run_limit : limit_q;
                    clr     = 1'b1;
                end
        endcase
        done_d = state_d == ST_HALTED && state_q != ST_HALTED;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_STEP;
            limit_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            limit_q <= limit_d;
            done_q  <= done_d;
        end
    cpu_run_counter #(.W(RUN_LIMIT_W)) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (cpu_en),
        .limit (limit_q),
        .count (retired),
        .last  (last)
    );
    assign state      = state_q;
    assign halt_cause = cause_q;
    assign done       = done_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: scoreboard bench checking cpu_run_ctrl against a cycle model of the run rules.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;
    logic        clk = 1'b0, rst = 1'b0, cmd_valid = 1'b0, bp_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] run_limit = '0, pc = '0, bp_addr = '0;
    logic        cpu_en, done;
    logic [1:0]  state, halt_cause;
    logic [31:0] retired;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    cpu_run_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .run_limit  (run_limit),
        .pc         (pc),
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        .bp_valid   (bp_valid),
        .bp_addr    (bp_addr),
`endif
        .cpu_en     (cpu_en),
        .state      (state),
        .retired    (retired),
        .halt_cause (halt_cause),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [1:0]  st;
        logic [31:0] ret;
        logic [1:0]  cause;
        logic        done;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    int chk_cnt = 0, pass_cnt = 0, en_cnt = 0, done_cnt = 0, s_en, s_done;
    bit rand_bp = 1'b0;

    // model: 0 idle, 1 run, 2 step, 3 halted
    int          m_state;
    logic [31:0] m_ret, m_lim, m_pc;
    logic [1:0]  m_cause;
    bit          m_done, m_fresh, m_en, m_hit;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        chk_cnt++;
        if (a === e) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    endtask

    task automatic model_reset();
        m_state = 0; m_ret = '0; m_lim = '0; m_cause = 2'd0;
        m_done = 0; m_fresh = 0; m_en = 0; m_hit = 0;
    endtask

    task automatic halt_with(input int c);
        m_state = 3; m_cause = 2'(c); m_done = 1;
    endtask

    task automatic model_edge();
        int go;
        if (!rst) begin
            model_reset();
            return;
        end
        go = cmd_valid ? int'(cmd_op) : 0;
        m_done = 0;
        if (m_en) begin
            m_pc += 32'd4;
            if (m_ret != 32'hFFFF_FFFF) m_ret++;
        end
        if (m_state == 0 || m_state == 3) begin
            if (go == 1) begin m_state = 1; m_ret = '0; m_lim = run_limit; m_fresh = 1; end
            else if (go == 2) begin m_state = 2; m_ret = '0; end
        end else if (m_state == 1) begin
            if (m_hit) halt_with(3);
            else if (m_lim != 0 && m_ret == m_lim) halt_with(2);
            else if (go == 3) halt_with(1);
            m_fresh = 0;
        end else halt_with(0);
    endtask

    task automatic present();
        pc    = m_pc;
        m_hit = BP && m_state == 1 && !m_fresh && bp_valid && pc == bp_addr;
        m_en  = m_state == 2 || (m_state == 1 && !m_hit);
        q.push_back('{m_en, 2'(m_state), m_ret, m_cause, m_done});
    endtask

    task automatic tick(input bit v, input bit [1:0] op, input bit [31:0] lim, input bit r = 1'b1);
        @(posedge clk);
        model_edge();
        #1;
        cmd_valid = v; cmd_op = op; run_limit = lim; rst = r;
        if (rand_bp) begin
            bp_valid = 1'($urandom_range(0, 1));
            bp_addr  = m_pc + 32'(4 * $urandom_range(0, 6));
        end
        if (!r) model_reset();
        present();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        m_pc = 32'h3000;
        fork
            forever begin
                @(negedge clk);
                if (q.size() > 0) begin
                    mon_e = q.pop_front();
                    chk("cpu_en", cpu_en, mon_e.en);
                    chk("state", state, mon_e.st);
                    chk("retired", retired, mon_e.ret);
                    chk("halt_cause", halt_cause, mon_e.cause);
                    chk("done", done, mon_e.done);
                    en_cnt   += int'(cpu_en);
                    done_cnt += int'(done);
                end
            end
        join_none

        repeat (3) tick(0, 2'd0, 0, 0);
        repeat (10) tick(1'($urandom_range(0, 1)), $urandom_range(0, 1) ? 2'd3 : 2'd0, $urandom);
        settle();
        chk("idle_state", state, 0);
        chk("idle_retired", retired, 0);
        chk("idle_en_cycles", en_cnt, 0);

        for (int i = 0; i < 3; i++) begin
            s_en = en_cnt;
            tick(1, 2'd2, 0);
            tick(0, 2'd0, 0);
            tick(0, 2'd0, 0);
            settle();
            chk("step_retired", retired, 1);
            chk("step_cause", halt_cause, 0);
            chk("step_en_cycles", en_cnt - s_en, 1);
        end

        s_en = en_cnt; s_done = done_cnt;
        tick(1, 2'd1, 30);
        repeat (40) tick(0, 2'd0, 0);
        settle();
        chk("limit_retired", retired, 30);
        chk("limit_cause", halt_cause, 2);
        chk("limit_state", state, 3);
        chk("limit_en_cycles", en_cnt - s_en, 30);
        chk("limit_done_pulses", done_cnt - s_done, 1);

        tick(1, 2'd1, 0);
        repeat (11) tick(0, 2'd0, 0);
        tick(1, 2'd3, 0);
        tick(0, 2'd0, 0);
        settle();
        chk("host_halt_retired", retired, 12);
        chk("host_halt_cause", halt_cause, 1);
        s_done = done_cnt;
        tick(1, 2'd3, 0);
        repeat (2) tick(0, 2'd0, 0);
        settle();
        chk("rehalt_state", state, 3);
        chk("rehalt_retired", retired, 12);
        chk("rehalt_cause", halt_cause, 1);
        chk("rehalt_done", done_cnt - s_done, 0);

        if (BP) begin
            m_pc = 32'h3000; bp_valid = 1'b1; bp_addr = 32'h3010;
            s_en = en_cnt;
            tick(1, 2'd1, 0);
            repeat (10) tick(0, 2'd0, 0);
            settle();
            chk("bp_retired", retired, 4);
            chk("bp_cause", halt_cause, 3);
            chk("bp_en_cycles", en_cnt - s_en, 4);
            tick(1, 2'd1, 0);
            repeat (3) tick(0, 2'd0, 0);
            settle();
            chk("bp_resume_retired", retired, 2);
            tick(1, 2'd3, 0);
            tick(0, 2'd0, 0);
            bp_valid = 1'b0;
        end

        tick(1, 2'd1, 0);
        repeat (8) tick(0, 2'd0, 0);
        settle();
        chk("mid_run_retired", retired, 7);
        chk("mid_run_en", cpu_en, 1);
        rst = 1'b0;
        #1;
        chk("async_rst_en", cpu_en, 0);
        chk("async_rst_retired", retired, 0);
        chk("async_rst_state", state, 0);
        s_done = done_cnt;
        tick(0, 2'd0, 0, 0);
        tick(0, 2'd0, 0, 1);
        repeat (3) tick(0, 2'd0, 0);
        settle();
        chk("post_rst_state", state, 0);
        chk("post_rst_retired", retired, 0);
        chk("post_rst_done", done_cnt - s_done, 0);

        rand_bp = BP;
        for (int i = 0; i < 2000; i++)
            tick($urandom_range(0, 3) == 0, 2'($urandom), $urandom_range(0, 40), $urandom_range(0, 399) != 0);
        rand_bp = 1'b0;
        tick(0, 2'd0, 0);
        settle();
        chk("scoreboard_drain", q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
